// File: rtl/dense_input_sequencer_if.sv
// Handshake bundle between the dense input sequencer, its feature RAM, the dense MAC and
// the run controller. The sequencer uses the slave view; the environment uses master.
interface dense_input_sequencer_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IDX_W  = 4
) ();
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     fm_rd_en;
    logic [ADDR_W-1:0]        fm_addr;
    logic signed [15:0]       fm_data;
    logic                     frame_start_out;
    logic                     ena_out;
    logic signed [15:0]       dense_input_out;
    logic                     frame_end_out;
    logic [IDX_W-1:0]         neuron_idx;
    logic                     mac_valid;
    logic signed [15:0]       mac_sum;
    logic                     res_valid;
    logic [IDX_W-1:0]         res_idx;
    logic signed [15:0]       res_data;

    modport master (
        output start, fm_data, mac_valid, mac_sum,
        input  busy, done, fm_rd_en, fm_addr, frame_start_out, ena_out, dense_input_out,
               frame_end_out, neuron_idx, res_valid, res_idx, res_data
    );

    modport slave (
        input  start, fm_data, mac_valid, mac_sum,
        output busy, done, fm_rd_en, fm_addr, frame_start_out, ena_out, dense_input_out,
               frame_end_out, neuron_idx, res_valid, res_idx, res_data
    );
endinterface

// File: rtl/dense_input_sequencer.sv
// Dense MAC input sequencer: streams a feature vector from a synchronous RAM into the dense
// MAC once per output neuron and re-emits each MAC result tagged with its neuron index.
module dense_input_sequencer #(
    parameter int unsigned N_IN   = 784,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IDX_W  = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    dense_input_sequencer_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StStart, StStream, StWait} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(N_OUT - 1);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic               rd_en_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               fs_q;
    logic [IDX_W-1:0]   idx_q;
    logic               res_valid_q;
    logic [IDX_W-1:0]   res_idx_q;
    logic signed [15:0] res_data_q;

    // Read-return stage (RAM latency) followed by the registered element stage.
    logic               p1_valid_q;
    logic               p1_last_q;
    logic               ena_q;
    logic               fe_q;
    logic signed [15:0] data_q;

    logic               pipe_idle;

    // A result is only accepted once the current frame's last element has left the pipe.
    assign pipe_idle = ~p1_valid_q & ~ena_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            fs_q        <= 1'b0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        state_q <= StStart;
                        busy_q  <= 1'b1;
                        fs_q    <= 1'b1;
                    end
                end
                StStart: begin
                    // Entered from WAIT with fs_q low: frame_start lands one cycle after res_valid.
                    if (fs_q) begin
                        fs_q    <= 1'b0;
                        state_q <= StStream;
                        rd_en_q <= 1'b1;
                        addr_q  <= '0;
                    end else begin
                        fs_q <= 1'b1;
                    end
                end
                StStream: begin
                    if (addr_q == LastAddr) begin
                        rd_en_q <= 1'b0;
                        state_q <= StWait;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                StWait: begin
                    if (bus_io.mac_valid && pipe_idle) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= bus_io.mac_sum;
                        res_idx_q   <= idx_q;
                        if (idx_q == LastIdx) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            idx_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= StStart;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            ena_q      <= 1'b0;
            fe_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            p1_valid_q <= rd_en_q;
            p1_last_q  <= rd_en_q && (addr_q == LastAddr);
            ena_q      <= p1_valid_q;
            fe_q       <= p1_last_q;
            data_q     <= p1_valid_q ? bus_io.fm_data : 16'sd0;
        end
    end

    assign bus_io.busy            = busy_q;
    assign bus_io.done            = done_q;
    assign bus_io.fm_rd_en        = rd_en_q;
    assign bus_io.fm_addr         = addr_q;
    assign bus_io.frame_start_out = fs_q;
    assign bus_io.ena_out         = ena_q;
    assign bus_io.dense_input_out = data_q;
    assign bus_io.frame_end_out   = fe_q;
    assign bus_io.neuron_idx      = idx_q;
    assign bus_io.res_valid       = res_valid_q;
    assign bus_io.res_idx         = res_idx_q;
    assign bus_io.res_data        = res_data_q;

endmodule
